// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator: double-buffered sprite placement latched at
// each VGA frame boundary, feeding a 2-stage pixel-to-ROM-address pipeline.
module sprite_addr_gen #(
    parameter int CHAR_W  = 64,
    parameter int CHAR_H  = 64,
    parameter int BOSS_W  = 128,
    parameter int BOSS_H  = 128,
    parameter int SPELL_W = 96,
    parameter int SPELL_H = 96
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        VGA_VS,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pos_wr,
    input  logic [1:0]  pos_sel,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        pos_en,
    input  logic        pos_flip,
    output logic [15:0] char_addr,
    output logic [18:0] boss_addr,
    output logic [16:0] spell_addr,
    output logic        char_vis,
    output logic        boss_vis,
    output logic        spell_vis,
    output logic [7:0]  frame_cnt,
    output logic        frame_start
);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
    } place_t;

    place_t sh_char, sh_boss, sh_spell;
    place_t act_char, act_boss, act_spell;
    logic   sh_char_flip, act_char_flip;

    logic vs_s, vs_hist;

    logic [10:0] c_dx, c_dy, b_dx, b_dy, s_dx, s_dy;
    logic        c_in, b_in, s_in, c_flip;

    // Sums are widened to 11 bits so boxes hanging off the right/bottom edge never wrap.
    function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                    input place_t p, input int w, input int h);
        logic [10:0] px1, py1, ox1, oy1;
        px1 = {1'b0, px};
        py1 = {1'b0, py};
        ox1 = {1'b0, p.x};
        oy1 = {1'b0, p.y};
        return p.en && (px1 >= ox1) && (px1 < ox1 + 11'(w))
                    && (py1 >= oy1) && (py1 < oy1 + 11'(h));
    endfunction

    assign frame_start = vs_hist & ~vs_s;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_s          <= 1'b1;
            vs_hist       <= 1'b1;
            sh_char       <= '0;
            sh_boss       <= '0;
            sh_spell      <= '0;
            sh_char_flip  <= 1'b0;
            act_char      <= '0;
            act_boss      <= '0;
            act_spell     <= '0;
            act_char_flip <= 1'b0;
            frame_cnt     <= 8'd0;
        end else begin
            vs_s    <= VGA_VS;
            vs_hist <= vs_s;
            if (pos_wr) begin
                case (pos_sel)
                    2'd0: begin
                        sh_char      <= '{x: pos_x, y: pos_y, en: pos_en};
                        sh_char_flip <= pos_flip;
                    end
                    2'd1:    sh_boss  <= '{x: pos_x, y: pos_y, en: pos_en};
                    2'd2:    sh_spell <= '{x: pos_x, y: pos_y, en: pos_en};
                    default: ;
                endcase
            end
            // Non-blocking copy picks up the pre-write shadow when a write lands on the boundary.
            if (frame_start) begin
                act_char      <= sh_char;
                act_boss      <= sh_boss;
                act_spell     <= sh_spell;
                act_char_flip <= sh_char_flip;
                frame_cnt     <= frame_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            c_dx   <= '0;
            c_dy   <= '0;
            c_in   <= 1'b0;
            c_flip <= 1'b0;
            b_dx   <= '0;
            b_dy   <= '0;
            b_in   <= 1'b0;
            s_dx   <= '0;
            s_dy   <= '0;
            s_in   <= 1'b0;
        end else begin
            c_dx   <= {1'b0, DrawX} - {1'b0, act_char.x};
            c_dy   <= {1'b0, DrawY} - {1'b0, act_char.y};
            c_in   <= in_box(DrawX, DrawY, act_char, CHAR_W, CHAR_H);
            c_flip <= act_char_flip;
            b_dx   <= {1'b0, DrawX} - {1'b0, act_boss.x};
            b_dy   <= {1'b0, DrawY} - {1'b0, act_boss.y};
            b_in   <= in_box(DrawX, DrawY, act_boss, BOSS_W, BOSS_H);
            s_dx   <= {1'b0, DrawX} - {1'b0, act_spell.x};
            s_dy   <= {1'b0, DrawY} - {1'b0, act_spell.y};
            s_in   <= in_box(DrawX, DrawY, act_spell, SPELL_W, SPELL_H);
        end
    end

    logic [10:0] c_col;
    assign c_col = c_flip ? (11'(CHAR_W - 1) - c_dx) : c_dx;

    // Address is forced to zero outside the box so ROM reads are deterministic.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            char_addr  <= '0;
            boss_addr  <= '0;
            spell_addr <= '0;
            char_vis   <= 1'b0;
            boss_vis   <= 1'b0;
            spell_vis  <= 1'b0;
        end else begin
            char_vis   <= c_in;
            boss_vis   <= b_in;
            spell_vis  <= s_in;
            char_addr  <= c_in ? 16'(32'(c_dy) * 32'(CHAR_W)  + 32'(c_col)) : '0;
            boss_addr  <= b_in ? 19'(32'(b_dy) * 32'(BOSS_W)  + 32'(b_dx))  : '0;
            spell_addr <= s_in ? 17'(32'(s_dy) * 32'(SPELL_W) + 32'(s_dx))  : '0;
        end
    end

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Directed bench for sprite_addr_gen with hand-computed expected addresses.
module tb_sprite_addr_gen;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        VGA_VS;
    logic [9:0]  DrawX, DrawY;
    logic        pos_wr;
    logic [1:0]  pos_sel;
    logic [9:0]  pos_x, pos_y;
    logic        pos_en, pos_flip;
    logic [15:0] char_addr;
    logic [18:0] boss_addr;
    logic [16:0] spell_addr;
    logic        char_vis, boss_vis, spell_vis;
    logic [7:0]  frame_cnt;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;
    int fs_count = 0;
    int fs_wide  = 0;
    int fs_base  = 0;
    logic fs_prev = 1'b0;

    sprite_addr_gen dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .VGA_VS     (VGA_VS),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .pos_wr     (pos_wr),
        .pos_sel    (pos_sel),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_en     (pos_en),
        .pos_flip   (pos_flip),
        .char_addr  (char_addr),
        .boss_addr  (boss_addr),
        .spell_addr (spell_addr),
        .char_vis   (char_vis),
        .boss_vis   (boss_vis),
        .spell_vis  (spell_vis),
        .frame_cnt  (frame_cnt),
        .frame_start(frame_start)
    );

    always #10 Clk = ~Clk;

    // Pulse counting and width tracking for the frame boundary strobe.
    always @(posedge Clk) begin
        if (frame_start === 1'b1) fs_count <= fs_count + 1;
        if (frame_start === 1'b1 && fs_prev === 1'b1) fs_wide <= fs_wide + 1;
        fs_prev <= (frame_start === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
        @(negedge Clk);
        DrawX = x;
        DrawY = y;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic write_sprite(input logic [1:0] sel, input logic [9:0] x, input logic [9:0] y,
                                input logic en, input logic flip);
        @(negedge Clk);
        pos_sel  = sel;
        pos_x    = x;
        pos_y    = y;
        pos_en   = en;
        pos_flip = flip;
        pos_wr   = 1'b1;
        @(negedge Clk);
        pos_wr   = 1'b0;
    endtask

    // Drop VS, wait (bounded) for the strobe, optionally write the spell on that very cycle.
    task automatic do_frame(input bit spell_on_edge);
        int n;
        @(negedge Clk);
        VGA_VS = 1'b0;
        n = 0;
        while (frame_start !== 1'b1 && n < 10) begin
            @(negedge Clk);
            n++;
        end
        if (frame_start !== 1'b1) checkOutput("frame_start_timeout", 32'(frame_start), 1);
        if (spell_on_edge) begin
            pos_sel = 2'd2;
            pos_x   = 10'd0;
            pos_y   = 10'd0;
            pos_en  = 1'b1;
            pos_wr  = 1'b1;
            @(negedge Clk);
            pos_wr  = 1'b0;
        end
        repeat (3) @(negedge Clk);
        VGA_VS = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b1; VGA_VS = 1'b1; DrawX = '0; DrawY = '0;
        pos_wr = 1'b0; pos_sel = '0; pos_x = '0; pos_y = '0; pos_en = 1'b0; pos_flip = 1'b0;
        @(posedge Clk); #1;
        checkOutput("in_reset_char_vis", 32'(char_vis), 0);
        checkOutput("in_reset_char_addr", 32'(char_addr), 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("rst_boss_vis", 32'(boss_vis), 0);
        checkOutput("rst_spell_vis", 32'(spell_vis), 0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 0);
        checkOutput("rst_frame_start", 32'(frame_start), 0);

        write_sprite(2'd0, 10'd100, 10'd50, 1'b1, 1'b0);
        applyStimulus(10'd110, 10'd60);
        checkOutput("shadow_not_live", 32'(char_vis), 0);
        do_frame(1'b0);
        checkOutput("frame_cnt_1", 32'(frame_cnt), 1);
        applyStimulus(10'd110, 10'd60);
        checkOutput("char_vis_650", 32'(char_vis), 1);
        checkOutput("char_addr_650", 32'(char_addr), 650);

        // Back-to-back pixels: one result per cycle, 2 cycles behind the input.
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (i >= 2) checkOutput("stream_addr", 32'(char_addr), 32'(640 + i - 2));
            if (i < 4) begin
                DrawX = 10'(100 + i);
                DrawY = 10'd60;
            end
        end

        write_sprite(2'd3, 10'd0, 10'd0, 1'b1, 1'b0);
        write_sprite(2'd0, 10'd100, 10'd50, 1'b1, 1'b1);
        do_frame(1'b0);
        applyStimulus(10'd10, 10'd10);
        checkOutput("sel3_char_vis", 32'(char_vis), 0);
        checkOutput("sel3_boss_vis", 32'(boss_vis), 0);
        checkOutput("sel3_spell_vis", 32'(spell_vis), 0);
        applyStimulus(10'd100, 10'd50);
        checkOutput("flip_vis", 32'(char_vis), 1);
        checkOutput("flip_addr_63", 32'(char_addr), 63);
        applyStimulus(10'd163, 10'd50);
        checkOutput("flip_right_vis", 32'(char_vis), 1);
        checkOutput("flip_right_addr", 32'(char_addr), 0);
        applyStimulus(10'd164, 10'd50);
        checkOutput("flip_out_vis", 32'(char_vis), 0);
        checkOutput("flip_out_addr", 32'(char_addr), 0);
        applyStimulus(10'd99, 10'd50);
        checkOutput("left_out_vis", 32'(char_vis), 0);

        write_sprite(2'd1, 10'd600, 10'd400, 1'b1, 1'b0);
        do_frame(1'b0);
        applyStimulus(10'd639, 10'd479);
        checkOutput("boss_edge_vis", 32'(boss_vis), 1);
        checkOutput("boss_edge_addr", 32'(boss_addr), 10151);
        applyStimulus(10'd5, 10'd479);
        checkOutput("boss_nowrap_vis", 32'(boss_vis), 0);
        checkOutput("boss_nowrap_addr", 32'(boss_addr), 0);

        do_frame(1'b1);
        applyStimulus(10'd10, 10'd10);
        checkOutput("spell_coincide_vis", 32'(spell_vis), 0);
        do_frame(1'b0);
        applyStimulus(10'd10, 10'd10);
        checkOutput("spell_next_vis", 32'(spell_vis), 1);
        checkOutput("spell_next_addr", 32'(spell_addr), 970);
        checkOutput("frame_cnt_5", 32'(frame_cnt), 5);

        // Mid-frame reset with a pending shadow write that must be discarded.
        write_sprite(2'd0, 10'd0, 10'd0, 1'b1, 1'b0);
        applyStimulus(10'd110, 10'd60);
        checkOutput("pre_reset_char_vis", 32'(char_vis), 1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("mid_rst_char_vis", 32'(char_vis), 0);
        checkOutput("mid_rst_char_addr", 32'(char_addr), 0);
        checkOutput("mid_rst_boss_vis", 32'(boss_vis), 0);
        checkOutput("mid_rst_spell_vis", 32'(spell_vis), 0);
        checkOutput("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        fs_base = fs_count;
        do_frame(1'b0);
        checkOutput("post_rst_frame_cnt", 32'(frame_cnt), 1);
        applyStimulus(10'd10, 10'd10);
        checkOutput("post_rst_char_vis", 32'(char_vis), 0);
        checkOutput("post_rst_spell_vis", 32'(spell_vis), 0);
        applyStimulus(10'd639, 10'd479);
        checkOutput("post_rst_boss_vis", 32'(boss_vis), 0);

        for (int f = 0; f < 255; f++) do_frame(1'b0);
        checkOutput("frame_cnt_wrap", 32'(frame_cnt), 0);
        checkOutput("frame_start_pulses", 32'(fs_count - fs_base), 256);
        checkOutput("frame_start_width", 32'(fs_wide), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_addr_gen.md
SPRITE_ADDR_GEN -- requirements
Module: sprite_addr_gen

Interface
REQ-001 Parameters SHALL be: CHAR_W 64, CHAR_H 64 (character sprite size, px); BOSS_W 128, BOSS_H 128; SPELL_W 96, SPELL_H 96.
REQ-002 Clk  in  1  system clock, 50 MHz; the block SHALL have one clock only.
REQ-003 Reset  in  1  synchronous, active-high.
REQ-004 VGA_VS  in  1  active-low vertical sync from VGA_controller.
REQ-005 DrawX, DrawY  in  10 each  current pixel coordinates.
REQ-006 pos_wr  in  1  single-cycle write strobe for sprite placement.
REQ-007 pos_sel  in  2  target of the write: 0 character, 1 boss, 2 spell, 3 ignored.
REQ-008 pos_x, pos_y  in  10 each  top-left corner of the sprite, in screen pixels.
REQ-009 pos_en  in  1  sprite enable for the write.
REQ-010 pos_flip  in  1  horizontal mirror; applied to the character only.
REQ-011 char_addr  out  16  character ROM read address.
REQ-012 boss_addr  out  19  boss ROM read address.
REQ-013 spell_addr  out  17  spell ROM read address.
REQ-014 char_vis, boss_vis, spell_vis  out  1 each  pixel lies inside an enabled sprite box.
REQ-015 frame_cnt  out  8  count of frames since reset.
REQ-016 frame_start  out  1  one-cycle pulse at each frame boundary.

Function
REQ-017 Shadow registers: one set per sprite, holding x, y, en and flip (flip for the character only).
- On pos_wr with pos_sel 0-2, the selected set SHALL be written at the next rising edge.
- pos_sel 3 SHALL write nothing.
REQ-018 Frame boundary: the first Clk cycle in which VGA_VS, registered once, is seen falling 1->0.
- frame_start SHALL pulse for exactly that cycle.
REQ-019 On frame_start, all shadow sets SHALL copy into the active sets in that same cycle, and frame_cnt SHALL increment, wrapping 255->0.
REQ-020 When pos_wr and frame_start coincide, the active set SHALL take the pre-write shadow value; the written value SHALL take effect from the following frame.
REQ-021 Stage 1 (registered), per sprite:
- dx = DrawX - x and dy = DrawY - y, computed as 11-bit unsigned;
- in_box = en AND DrawX >= x AND DrawX < x+W AND DrawY >= y AND DrawY < y+H;
- the x+W and y+H sums SHALL be computed at 11 bits, with no wrap.
REQ-022 Stage 2 (registered): addr = dy*W + dx; for a flipped character, addr = dy*W + (W-1-dx). vis = in_box.
REQ-023 Latency from DrawX/DrawY to addr/vis SHALL be exactly 2 Clk cycles, fully pipelined: one new result every cycle.
REQ-024 When vis = 0, the corresponding addr SHALL be 0.
REQ-025 A sprite extending past x = 639 or y = 479 SHALL still report vis for in-range pixels; no coordinate SHALL wrap to 0.
REQ-026 The block SHALL use only active registers in the address path; shadow writes SHALL never alter the current frame.

Reset
REQ-027 While Reset is 1 at a rising edge, the block SHALL clear:
- all shadow and active sets to 0 (en = 0);
- the pipeline registers;
- frame_cnt to 0;
- the VS history register to 1.
REQ-028 During and after reset, all addr, vis and frame_start outputs SHALL be 0 until enabled sprites are latched.
REQ-029 A reset asserted mid-frame SHALL discard all pending shadow writes; no frame_start SHALL be generated by the reset itself.

Verification
REQ-030 Write char x=100, y=50, en=1, then one VS falling edge; drive DrawX=110, DrawY=60 -> two cycles later char_vis=1, char_addr=650.
REQ-031 Same placement with flip=1, DrawX=100, DrawY=50 -> char_addr=63; DrawX=164 -> char_vis=0, char_addr=0.
REQ-032 Boss x=600, y=400, en=1; DrawX=639, DrawY=479 -> boss_vis=1, boss_addr=79*128+39=10151; DrawX=5 -> boss_vis=0.
REQ-033 Write spell en=1 in the same cycle as frame_start -> spell_vis stays 0 for that whole frame and becomes valid after the next frame_start.
REQ-034 Run 256 VS falling edges -> frame_cnt returns to 0, frame_start pulses exactly 256 times, each 1 cycle wide.
REQ-035 Assert Reset for 1 cycle mid-frame with sprites enabled -> within 2 cycles all vis=0, addr=0, frame_cnt=0; the next VS falling edge gives frame_cnt=1 with all sprites disabled.
